ctr_xor_stage: RTL and testbench
================================

# ctr_xor_stage

Counter-mode data stage directly downstream of the nonce generator. Accepts the 128-bit nonce {iv, counter} once per message. For each 128-bit plaintext block it derives a counter block, requests a keystream block from the cipher core over a req/ack handshake, and emits ciphertext = plaintext XOR keystream over a valid/ready handshake. Decryption uses the same path with ciphertext on the data input.

## Interface
- CTR_W, 64: width of the per-block increment field, the low bits of the counter block; upper 128-CTR_W bits pass through unchanged.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- nonce_in  in  128  nonce from the nonce generator, {iv[63:0], counter[63:0]}.
- nonce_valid  in  1  nonce_in is valid.
- nonce_ready  out  1  stage idle and will take a nonce.
- pt_in  in  128  input data block.
- pt_last  in  1  qualifies pt_in as the final block of the message.
- pt_valid  in  1  pt_in/pt_last valid.
- pt_ready  out  1  stage will take a block this cycle.
- ks_block  out  128  counter block sent to the cipher core.
- ks_req  out  1  keystream request; held until acknowledged.
- ks_in  in  128  keystream block from the cipher core.
- ks_ack  in  1  ks_in valid; completes the request.
- ct_out  out  128  output block, pt XOR ks.
- ct_last  out  1  ct_out is the final block of the message.
- ct_valid  out  1  ct_out valid; held until ct_ready.
- ct_ready  in  1  downstream accepts ct_out.
- ctr_wrap  out  1  sticky; set when the increment field wraps within a message.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, WAIT_KS, OUT.
- IDLE: nonce_ready=1. When nonce_valid=1: latch base=nonce_in, clear blk and ctr_wrap, go to LOAD.
- LOAD: pt_ready=1. When pt_valid=1: latch pt_in and pt_last. Register ks_block = {base[127:CTR_W], base[CTR_W-1:0]+blk}; the low field adds modulo 2^CTR_W with no carry into the upper bits. Assert ks_req and go to WAIT_KS.
- WAIT_KS: ks_req=1 and ks_block stable. When ks_ack=1: register ct_out = pt XOR ks_in and ct_last = latched pt_last, drop ks_req, go to OUT.
- OUT: ct_valid=1; ct_out and ct_last stable. On ct_valid and ct_ready:
  - if ct_last: go to IDLE;
  - else: blk <= blk+1 and go to LOAD.
  - If base[CTR_W-1:0]+blk+1 overflows 2^CTR_W, set ctr_wrap. It stays set until the next nonce is accepted. Operation continues.
- nonce_valid and pt_valid outside their accepting states are ignored; there is no backlog.
- ks_ack outside WAIT_KS is ignored.
- pt_ready, nonce_ready and ct_valid are decoded from state only; none depends combinationally on the matching valid/ready input.
- Reset low at any time: FSM to IDLE. All outputs go to 0: ks_block, ct_out, ct_last, ct_valid, ks_req, ctr_wrap, busy, pt_ready. nonce_ready is 1 after release. Any in-flight request is abandoned; a late ks_ack is ignored.

## Timing
- Nonce accepted at edge N: LOAD (pt_ready=1) from cycle N+1.
- Block accepted at edge M: ks_req=1 and ks_block valid from cycle M+1.
- ks_ack sampled high at edge K: ct_valid=1 from cycle K+1; ks_req low from K+1.
- Output handshake at edge P: pt_ready=1 from cycle P+1 for a non-last block; nonce_ready=1 from P+1 for a last block.
- Best case, with ks_ack and ct_ready tied high: 3 cycles per block, 1 extra cycle per message for the nonce.
- ks_req and ct_valid never drop without their handshake, except on reset.

## Test plan
- Single block: nonce=128'hba23890ace346bf1_0000000000000005, pt=128'h0123…ef with last=1, ks_in=128'hFFFF…FF. Expect ks_block=nonce exactly; ct_out=~pt; ct_last=1; back to IDLE with nonce_ready=1.
- Three-block message, low field 64'h0: expect ks_block low fields 0, 1, 2 in order; ct_last only on the third block; upper 64 bits equal ba23890ace346bf1 throughout.
- Wrap: low field 64'hFFFF_FFFF_FFFF_FFFF, two blocks. Expect second ks_block low=64'h0, upper unchanged, and ctr_wrap=1 after the first output handshake. Next nonce clears ctr_wrap.
- Backpressure: hold ks_ack low 5 cycles, then ct_ready low 4 cycles. Expect ks_req and ks_block stable throughout, ct_out stable while waiting, no duplicated or lost block.
- Reset mid-WAIT_KS: drop reset, then pulse ks_ack after release. Expect all outputs 0 during reset, nonce_ready=1 after release, ct_valid stays 0.
- Ignored inputs: pt_valid in IDLE, nonce_valid in LOAD, ks_ack in OUT. Expect no state change and no pt_ready or nonce_ready asserted out of state.

Source files
------------

// File: rtl/ctr_xor_stage.sv
// Counter-mode data stage: turns each data block into a counter block for the cipher
// core, then XORs the returned keystream onto the block and hands it downstream.
module ctr_xor_stage #(
    parameter int CTR_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] nonce_in,
    input  logic         nonce_valid,
    output logic         nonce_ready,
    input  logic [127:0] pt_in,
    input  logic         pt_last,
    input  logic         pt_valid,
    output logic         pt_ready,
    output logic [127:0] ks_block,
    output logic         ks_req,
    input  logic [127:0] ks_in,
    input  logic         ks_ack,
    output logic [127:0] ct_out,
    output logic         ct_last,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic         ctr_wrap,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_KS = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t             state;
    logic [127:0]       base;
    logic [CTR_W-1:0]   blk;
    logic [127:0]       pt_reg;
    logic               last_reg;
    logic [CTR_W:0]     next_sum;

    // Carry out of base_low + blk + 1 marks the increment field wrapping on the next block.
    assign next_sum = {1'b0, base[CTR_W-1:0]} + {1'b0, blk} + {{CTR_W{1'b0}}, 1'b1};

    assign nonce_ready = (state == IDLE);
    assign pt_ready    = (state == LOAD);
    assign ks_req      = (state == WAIT_KS);
    assign ct_valid    = (state == OUT);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            base     <= '0;
            blk      <= '0;
            pt_reg   <= '0;
            last_reg <= 1'b0;
            ks_block <= '0;
            ct_out   <= '0;
            ct_last  <= 1'b0;
            ctr_wrap <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (nonce_valid) begin
                        base     <= nonce_in;
                        blk      <= '0;
                        ctr_wrap <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (pt_valid) begin
                        pt_reg   <= pt_in;
                        last_reg <= pt_last;
                        ks_block <= {base[127:CTR_W], base[CTR_W-1:0] + blk};
                        state    <= WAIT_KS;
                    end
                end
                WAIT_KS: begin
                    if (ks_ack) begin
                        ct_out  <= pt_reg ^ ks_in;
                        ct_last <= last_reg;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (ct_ready) begin
                        if (next_sum[CTR_W]) begin
                            ctr_wrap <= 1'b1;
                        end
                        if (ct_last) begin
                            state <= IDLE;
                        end else begin
                            blk   <= blk + {{(CTR_W-1){1'b0}}, 1'b1};
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_xor_stage.sv
// Directed bench for ctr_xor_stage: single/multi-block messages, counter wrap,
// backpressure, mid-request reset and ignored handshakes.
module tb_ctr_xor_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] nonce_in = '0;
    logic         nonce_valid = 1'b0;
    logic         nonce_ready;
    logic [127:0] pt_in = '0;
    logic         pt_last = 1'b0;
    logic         pt_valid = 1'b0;
    logic         pt_ready;
    logic [127:0] ks_block;
    logic         ks_req;
    logic [127:0] ks_in = '0;
    logic         ks_ack = 1'b0;
    logic [127:0] ct_out;
    logic         ct_last;
    logic         ct_valid;
    logic         ct_ready = 1'b0;
    logic         ctr_wrap;
    logic         busy;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [63:0]  IV = 64'hba23890ace346bf1;
    localparam logic [127:0] PT = 128'h0123456789abcdef0123456789abcdef;

    ctr_xor_stage #(.CTR_W(64)) dut (
        .clk(clk), .reset(reset),
        .nonce_in(nonce_in), .nonce_valid(nonce_valid), .nonce_ready(nonce_ready),
        .pt_in(pt_in), .pt_last(pt_last), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ks_block(ks_block), .ks_req(ks_req), .ks_in(ks_in), .ks_ack(ks_ack),
        .ct_out(ct_out), .ct_last(ct_last), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .ctr_wrap(ctr_wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nonce(input logic [127:0] n);
        check_output("idle_nonce_ready", 128'(nonce_ready), 128'd1);
        nonce_in    = n;
        nonce_valid = 1'b1;
        tick();
        nonce_valid = 1'b0;
        check_output("load_pt_ready", 128'(pt_ready), 128'd1);
        check_output("load_nonce_ready", 128'(nonce_ready), 128'd0);
        check_output("load_busy", 128'(busy), 128'd1);
    endtask

    // One block through LOAD -> WAIT_KS -> OUT with optional ack/ready stalls.
    task automatic do_block(input logic [127:0] pt, input logic last, input logic [127:0] ks,
                            input logic [127:0] exp_blk, input int ack_wait, input int rdy_wait);
        check_output("blk_pt_ready", 128'(pt_ready), 128'd1);
        pt_in    = pt;
        pt_last  = last;
        pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        pt_in    = '0;
        check_output("ks_req_set", 128'(ks_req), 128'd1);
        check_output("ks_block", ks_block, exp_blk);
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            check_output("ks_req_hold", 128'(ks_req), 128'd1);
            check_output("ks_block_hold", ks_block, exp_blk);
        end
        ks_in  = ks;
        ks_ack = 1'b1;
        tick();
        ks_ack = 1'b0;
        ks_in  = '0;
        check_output("ct_valid_set", 128'(ct_valid), 128'd1);
        check_output("ks_req_drop", 128'(ks_req), 128'd0);
        check_output("ct_out", ct_out, pt ^ ks);
        check_output("ct_last", 128'(ct_last), 128'(last));
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            check_output("ct_valid_hold", 128'(ct_valid), 128'd1);
            check_output("ct_out_hold", ct_out, pt ^ ks);
        end
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;
        check_output("ct_valid_drop", 128'(ct_valid), 128'd0);
        if (last) check_output("end_nonce_ready", 128'(nonce_ready), 128'd1);
        else      check_output("next_pt_ready", 128'(pt_ready), 128'd1);
    endtask

    initial begin
        // Reset state
        #2;
        check_output("rst_ks_block", ks_block, 128'd0);
        check_output("rst_ct_out", ct_out, 128'd0);
        check_output("rst_flags", {122'd0, ct_last, ct_valid, ks_req, ctr_wrap, busy, pt_ready}, 128'd0);
        check_output("rst_nonce_ready", 128'(nonce_ready), 128'd1);
        tick();
        reset = 1'b1;
        tick();

        // Single block, all-ones keystream
        send_nonce({IV, 64'h5});
        do_block(PT, 1'b1, {128{1'b1}}, {IV, 64'h5}, 0, 0);
        check_output("single_ct_inv", ct_out, 128'hfedcba9876543210fedcba9876543210);
        check_output("single_idle", 128'(busy), 128'd0);

        // Three-block message
        send_nonce({IV, 64'h0});
        do_block(128'h11, 1'b0, 128'hA5A5, {IV, 64'h0}, 0, 0);
        do_block(128'h22, 1'b0, 128'h5A5A, {IV, 64'h1}, 0, 0);
        do_block(128'h33, 1'b1, 128'hFF00, {IV, 64'h2}, 0, 0);

        // Counter wrap
        send_nonce({IV, 64'hFFFF_FFFF_FFFF_FFFF});
        check_output("wrap_clear_start", 128'(ctr_wrap), 128'd0);
        do_block(PT, 1'b0, 128'h1, {IV, 64'hFFFF_FFFF_FFFF_FFFF}, 0, 0);
        check_output("wrap_set", 128'(ctr_wrap), 128'd1);
        do_block(PT, 1'b1, 128'h2, {IV, 64'h0}, 0, 0);
        check_output("wrap_sticky", 128'(ctr_wrap), 128'd1);
        send_nonce({IV, 64'h10});
        check_output("wrap_cleared", 128'(ctr_wrap), 128'd0);

        // Backpressure on both handshakes, then a follow-on block
        do_block(PT, 1'b0, 128'hDEAD_BEEF, {IV, 64'h10}, 5, 4);
        do_block(PT, 1'b1, 128'hCAFE, {IV, 64'h11}, 0, 0);

        // Ignored inputs: pt_valid in IDLE
        pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        check_output("ign_pt_in_idle", {126'd0, busy, pt_ready}, 128'd0);
        send_nonce({IV, 64'h20});
        // nonce_valid in LOAD must not re-latch the base
        nonce_in    = {64'h0, 64'h99};
        nonce_valid = 1'b1;
        tick();
        nonce_valid = 1'b0;
        check_output("ign_nonce_in_load", {126'd0, nonce_ready, pt_ready}, 128'd1);
        pt_in = PT; pt_last = 1'b1; pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        check_output("ign_base_kept", ks_block, {IV, 64'h20});
        ks_in = 128'h3; ks_ack = 1'b1;
        tick();
        // ks_ack in OUT must not overwrite the output
        ks_in = 128'h7777;
        tick();
        ks_ack = 1'b0;
        check_output("ign_ack_in_out", ct_out, PT ^ 128'h3);
        check_output("ign_ack_valid", 128'(ct_valid), 128'd1);
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;

        // Reset in WAIT_KS, late ack ignored
        send_nonce({IV, 64'h30});
        pt_in = PT; pt_last = 1'b0; pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        check_output("mid_ks_req", 128'(ks_req), 128'd1);
        reset = 1'b0;
        #2;
        check_output("mid_rst_ks_block", ks_block, 128'd0);
        check_output("mid_rst_flags", {122'd0, ct_last, ct_valid, ks_req, ctr_wrap, busy, pt_ready}, 128'd0);
        tick();
        reset = 1'b1;
        ks_in = 128'hFF; ks_ack = 1'b1;
        tick();
        ks_ack = 1'b0;
        check_output("late_ack_ct_valid", 128'(ct_valid), 128'd0);
        check_output("late_ack_nonce_ready", 128'(nonce_ready), 128'd1);
        check_output("late_ack_ct_out", ct_out, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
